// File: rtl/pred_uart_pkg.sv
// Shared types, ASCII constants and class-to-character mapping for the
// prediction UART reporter.
package pred_uart_pkg;

   // NEXT_CHAR names the stop-to-start hand-off between characters of one
   // message; it costs no clock cycle of its own.
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      NEXT_CHAR
   } uart_state_t;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_QMARK = 8'h3F;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;

   function automatic logic [7:0] class_to_ascii(input logic [3:0] cls);
      if (cls < 4'd10) return ASCII_ZERO + {4'h0, cls};
      return ASCII_QMARK;
   endfunction

endpackage

// File: rtl/prediction_uart_tx_byte.sv
// Single-byte 8N1 serializer. ready is high in IDLE and on the last cycle of
// the stop bit, so a new start there chains characters with no idle gap.
module uart_tx_byte
   import pred_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data,
   output logic       ready,
   output logic       tx
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   uart_state_t   state, state_nxt;
   logic [BW-1:0] baud, baud_nxt;
   logic [2:0]    bit_idx, bit_idx_nxt;
   logic [7:0]    shreg, shreg_nxt;
   logic          tx_nxt;
   logic          bit_end;

   assign bit_end = (baud == BAUD_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         baud    <= '0;
         bit_idx <= '0;
         tx      <= 1'b1;
      end else begin
         state   <= state_nxt;
         baud    <= baud_nxt;
         bit_idx <= bit_idx_nxt;
         tx      <= tx_nxt;
      end
   end

   always_ff @(posedge clk) begin
      shreg <= shreg_nxt;
   end

   always_comb begin
      state_nxt   = state;
      baud_nxt    = bit_end ? '0 : baud + 1'b1;
      bit_idx_nxt = bit_idx;
      shreg_nxt   = shreg;
      tx_nxt      = tx;
      ready       = 1'b0;
      case (state)
         IDLE: begin
            ready    = 1'b1;
            baud_nxt = '0;
            if (start) begin
               state_nxt = START;
               tx_nxt    = 1'b0;
               shreg_nxt = data;
            end
         end
         START: begin
            if (bit_end) begin
               state_nxt   = DATA;
               tx_nxt      = shreg[0];
               shreg_nxt   = {1'b0, shreg[7:1]};
               bit_idx_nxt = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_idx == 3'd7) begin
                  state_nxt = STOP;
                  tx_nxt    = 1'b1;
               end else begin
                  bit_idx_nxt = bit_idx + 3'd1;
                  tx_nxt      = shreg[0];
                  shreg_nxt   = {1'b0, shreg[7:1]};
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               ready = 1'b1;
               if (start) begin
                  state_nxt = START;
                  tx_nxt    = 1'b0;
                  shreg_nxt = data;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: rtl/prediction_uart_tx.sv
// Reports each argmax prediction as an ASCII digit over 8N1 UART.
// Define PRED_UART_CRLF_EN to follow each digit with CR and LF.
module prediction_uart_tx
   import pred_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int PIPE_LAT     = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       done_in,
   input  logic [3:0] class_in,
   output logic       tx,
   output logic       busy,
   output logic [3:0] pred,
   output logic       pred_valid,
   output logic       dropped
);

   logic                done_q;
   logic [PIPE_LAT-1:0] dly;
   logic                rise, capture;
   logic                ser_ready, ser_start;
   logic [7:0]          ser_data;
   logic                msg_start, last_char, avail;

   assign rise    = done_in & ~done_q;
   assign capture = dly[PIPE_LAT-1];

`ifdef PRED_UART_CRLF_EN
   logic [1:0] char_idx;
   logic       next_char;

   assign last_char = (char_idx == 2'd2);
   assign next_char = busy & ser_ready & ~last_char;
   assign ser_start = msg_start | next_char;

   always_comb begin
      ser_data = class_to_ascii(class_in);
      if (!msg_start) ser_data = (char_idx == 2'd0) ? ASCII_CR : ASCII_LF;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)            char_idx <= '0;
      else if (msg_start) char_idx <= '0;
      else if (next_char) char_idx <= char_idx + 2'd1;
   end
`else
   assign last_char = 1'b1;
   assign ser_start = msg_start;
   assign ser_data  = class_to_ascii(class_in);
`endif

   // A capture may start a message only when the line is free, including the
   // edge that ends the final stop bit of the previous message.
   assign avail     = ser_ready & (~busy | last_char);
   assign msg_start = capture & avail;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_q     <= 1'b0;
         dly        <= '0;
         pred       <= '0;
         pred_valid <= 1'b0;
         dropped    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         done_q  <= done_in;
         dly     <= (dly << 1) | PIPE_LAT'(rise);
         dropped <= capture & ~avail;
         if (capture) begin
            pred       <= class_in;
            pred_valid <= 1'b1;
         end
         if (msg_start)                          busy <= 1'b1;
         else if (busy & ser_ready & last_char)  busy <= 1'b0;
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_ser (
      .clk  (clk),
      .rst  (rst),
      .start(ser_start),
      .data (ser_data),
      .ready(ser_ready),
      .tx   (tx)
   );

endmodule

// File: tb/tb_prediction_uart_tx.sv
// Self-checking bench for prediction_uart_tx: timeline model of the serial
// output plus directed frame checks and randomized done_in/class_in traffic.
module tb_prediction_uart_tx;

   localparam int CPB = 4;
   localparam int LAT = 3;
`ifdef PRED_UART_CRLF_EN
   localparam int NCH = 3;
`else
   localparam int NCH = 1;
`endif
   localparam int MSG_CYC = NCH * 10 * CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       done_in = 1'b0;
   logic [3:0] class_in = 4'd0;
   logic       tx, busy, pred_valid, dropped;
   logic [3:0] pred;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   prediction_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .PIPE_LAT    (LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .done_in   (done_in),
      .class_in  (class_in),
      .tx        (tx),
      .busy      (busy),
      .pred      (pred),
      .pred_valid(pred_valid),
      .dropped   (dropped)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] chr_of(input logic [3:0] c);
      return (c < 10) ? 8'h30 + 8'(c) : 8'h3F;
   endfunction

   // Timeline model: every message is a precomputed list of per-cycle line
   // levels; the line is busy exactly while that list is non-empty.
   bit         txq[$];
   int         capq[$];
   int         cyc = 0;
   bit         m_prev = 1'b0;
   logic [3:0] m_pred = 4'd0;
   bit         m_valid = 1'b0;
   bit         m_drop = 1'b0;

   task automatic push_char(input logic [7:0] ch);
      logic [9:0] fr;
      fr = {1'b1, ch, 1'b0};
      for (int b = 0; b < 10; b++)
         for (int k = 0; k < CPB; k++) txq.push_back(fr[b]);
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         txq.delete();
         capq.delete();
         m_prev  = 1'b0;
         m_pred  = 4'd0;
         m_valid = 1'b0;
         m_drop  = 1'b0;
      end else begin
         cyc++;
         if (txq.size() > 0) void'(txq.pop_front());
         m_drop = 1'b0;
         if (capq.size() > 0 && capq[0] == cyc) begin
            void'(capq.pop_front());
            m_pred  = class_in;
            m_valid = 1'b1;
            if (txq.size() == 0) begin
               push_char(chr_of(class_in));
`ifdef PRED_UART_CRLF_EN
               push_char(8'h0D);
               push_char(8'h0A);
`endif
            end else begin
               m_drop = 1'b1;
            end
         end
         if (done_in && !m_prev) capq.push_back(cyc + LAT);
         m_prev = done_in;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_tx", tx, (txq.size() > 0) ? txq[0] : 1'b1);
         chk("model_busy", busy, txq.size() > 0);
         chk("model_pred", pred, m_pred);
         chk("model_pred_valid", pred_valid, m_valid);
         chk("model_dropped", dropped, m_drop);
      end
   end

   // Raise done_in for one cycle; returns at the negedge after the capture edge.
   task automatic start_msg(input logic [3:0] cls);
      @(negedge clk);
      done_in  = 1'b1;
      class_in = cls;
      @(negedge clk);
      done_in = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("busy_before_capture", busy, 1'b0);
      @(negedge clk);
      chk("pin_pred", pred, cls);
      chk("pin_pred_valid", pred_valid, 1'b1);
      chk("pin_busy_rise", busy, 1'b1);
      chk("pin_tx_fall", tx, 1'b0);
   endtask

   task automatic pin_frame(input logic [3:0] cls, input logic [7:0] digit);
      logic [7:0] chars [3];
      logic [9:0] fr;
      int         busy_cnt;
      chars[0] = digit;
      chars[1] = 8'h0D;
      chars[2] = 8'h0A;
      busy_cnt = 0;
      start_msg(cls);
      for (int j = 0; j < MSG_CYC; j++) begin
         fr = {1'b1, chars[j / (10 * CPB)], 1'b0};
         chk("pin_tx_bit", tx, fr[(j % (10 * CPB)) / CPB]);
         if (busy) busy_cnt++;
         @(negedge clk);
      end
      chk("pin_busy_len", busy_cnt, MSG_CYC);
      chk("pin_busy_fall", busy, 1'b0);
      chk("pin_tx_idle", tx, 1'b1);
   endtask

   initial begin
      int k;
      int drops;
      repeat (3) @(negedge clk);
      chk("reset_tx", tx, 1'b1);
      chk("reset_busy", busy, 1'b0);
      chk("reset_pred", pred, 4'd0);
      chk("reset_pred_valid", pred_valid, 1'b0);
      chk("reset_dropped", dropped, 1'b0);
      rst = 1'b0;
      chk_en = 1'b1;
      repeat (5) @(negedge clk);

      pin_frame(4'd7, 8'h37);
      repeat (8) @(negedge clk);
      pin_frame(4'd12, 8'h3F);
      repeat (8) @(negedge clk);

      // Second rise 10 cycles into a frame must be dropped, not queued.
      start_msg(4'd4);
      repeat (9) @(negedge clk);
      done_in  = 1'b1;
      class_in = 4'd2;
      @(negedge clk);
      done_in = 1'b0;
      repeat (3) @(negedge clk);
      chk("drop_pulse", dropped, 1'b1);
      chk("drop_pred", pred, 4'd2);
      drops = 1;
      @(negedge clk);
      chk("drop_one_cycle", dropped, 1'b0);
      k = 0;
      while (busy && k < 200) begin
         @(negedge clk);
         if (dropped) drops++;
         k++;
      end
      chk("drop_frame_len", 14 + k, MSG_CYC);
      chk("drop_count", drops, 1);
      repeat (20) @(negedge clk);
      chk("drop_no_second_busy", busy, 1'b0);
      chk("drop_no_second_tx", tx, 1'b1);

      // Reset during data bit 3 of 0x34 (bit value 0).
      start_msg(4'd4);
      repeat (17) @(negedge clk);
      chk("pre_reset_tx", tx, 1'b0);
      #1 rst = 1'b1;
      #1;
      chk("async_reset_tx", tx, 1'b1);
      chk("async_reset_busy", busy, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      pin_frame(4'd5, 8'h35);
      pin_frame(4'd3, 8'h33);

      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 9) == 0) done_in = ~done_in;
         class_in = 4'($urandom_range(0, 15));
      end
      done_in = 1'b0;
      repeat (MSG_CYC + 20) @(negedge clk);
      chk("final_idle_busy", busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
